uart_word_loader: RTL
=====================

# uart_word_loader

Parametrised serial program loader: deserialises a UART byte stream, assembles big-endian words of configurable width, and emits each word with an auto-incrementing byte address and a one-cycle valid strobe for direct connection to the program-memory write port. It generalises the fixed 8N1/32-bit byte-to-word path with configurable baud divisor, parity, word size and base address. It adds framing/parity error reporting and partial-word timeout recovery.

## Interface
- CLKS_PER_BIT, 694 — clock cycles per UART bit (80 MHz / 115200); minimum 4.
- PARITY, PARITY_NONE — PARITY_NONE / PARITY_EVEN / PARITY_ODD (from uart_pkg).
- WORD_BYTES, 4 — bytes per assembled word; 1..8.
- ADDR_WIDTH, 32 — width of byte_address.
- BASE_ADDR, 0 — address of first word after reset or load start.
- TIMEOUT_BITS, 32 — idle bit-times after which a partial word is discarded; 0 disables.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- load_enable  in  1  accept bytes into words; low drops received bytes.
- instruction_word  out  8*WORD_BYTES  assembled word, first received byte in MSBs.
- byte_address  out  ADDR_WIDTH  address of instruction_word.
- word_valid  out  1  one-cycle strobe; instruction_word/byte_address valid this cycle.
- frame_error  out  1  one-cycle strobe: stop bit sampled low.
- parity_error  out  1  one-cycle strobe: parity mismatch.
- busy  out  1  high while a byte is being received or a partial word is held.

## Operation
- rx passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised copy.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: synchronised rx low -> START, bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles sample rx; low -> DATA, high -> IDLE (glitch, no strobe).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first into shift register.
  - PARITY (skipped when PARITY_NONE): sample one bit, compare to even/odd parity of data.
  - STOP: sample after CLKS_PER_BIT; high and parity ok -> byte_done; low -> frame_error; parity bad -> parity_error (frame_error wins if both). Return to IDLE immediately after sampling (no half-bit wait).
- Assembler: on byte_done with load_enable high, shift byte into word register from LSB side, increment byte_count. When byte_count reaches WORD_BYTES: word_valid, byte_count -> 0.
- On frame_error or parity_error: partial word discarded, byte_count -> 0; byte_address unchanged.
- byte_address: holds BASE_ADDR after reset; advances by WORD_BYTES in the cycle after each word_valid; wraps modulo 2^ADDR_WIDTH.
- load_enable rising edge: byte_address -> BASE_ADDR, byte_count -> 0. load_enable low: bytes dropped, byte_count -> 0.
- Timeout: byte_count ≠ 0 and no start bit for TIMEOUT_BITS*CLKS_PER_BIT cycles -> byte_count -> 0, no strobe.

## Timing
- Reset: FSM IDLE, byte_count 0, instruction_word 0, byte_address BASE_ADDR, all strobes 0, busy 0.
- Reset mid-byte: reception aborted, no strobe; next falling edge starts fresh.
- word_valid asserts exactly 1 cycle after the stop-bit sample of the last byte; instruction_word holds until next word_valid.
- Sampling point: synchroniser delay 2 + CLKS_PER_BIT/2 + n*CLKS_PER_BIT cycles after start edge.
- Back-to-back bytes with zero idle time must be received without loss.
- Error strobes and word_valid are mutually exclusive in any cycle.

## Structure
- uart_pkg: parity_t enum (PARITY_NONE/EVEN/ODD), rx_state_t enum, shared baud constants.
- Sub-module uart_rx_core: synchroniser + RX FSM, outputs byte, byte_done, frame_error, parity_error. uart_word_loader instantiates it and adds assembler, address counter, timeout counter.

## Test plan
- Default params, 8N1: bytes 00 40 00 93 00 80 01 13 -> word_valid twice: 0x00400093 @ 0x0, 0x00800113 @ 0x4.
- PARITY_EVEN, WORD_BYTES=2: bytes A5 5A with correct parity -> 0xA55A @ BASE_ADDR; repeat with wrong parity on 5A -> parity_error, no word, next AB CD -> 0xABCD at same address.
- Stop bit forced low on 3rd byte of 4 -> frame_error 1 cycle, partial discarded; following 4 bytes 11 22 33 44 -> 0x11223344 @ 0x0.
- rx glitch low for CLKS_PER_BIT/4 -> no strobes, FSM returns IDLE.
- Two bytes then idle > TIMEOUT_BITS bit-times, then DE AD BE EF -> 0xDEADBEEF (no stale bytes), busy low during idle after timeout.
- ADDR_WIDTH=4, 5 words -> addresses 0,4,8,C,0; reset asserted mid-byte of 6th -> no strobes, address 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the serial program loader.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 694;
    localparam int unsigned DATA_BITS            = 8;

    // Parity bit a transmitter would send for this data byte.
    function automatic logic parity_bit(input parity_t mode, input logic [DATA_BITS-1:0] data);
        return (mode == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser plus bit-sampling FSM with parity and stop checks.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter parity_t     PARITY       = PARITY_NONE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] byte_o,
    output logic                 byte_done_c,
    output logic                 frame_error_c,
    output logic                 parity_error_c,
    output logic                 busy_c
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW   = $clog2(DATA_BITS);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    logic                 rx_meta_q;
    logic                 rx_sync_q;
    rx_state_t            state_q;
    logic [CW-1:0]        clk_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bit_q;

    logic half_tick_c;
    logic bit_tick_c;
    logic stop_tick_c;
    logic parity_bad_c;

    assign half_tick_c  = (clk_cnt_q == CW'(HALF - 1));
    assign bit_tick_c   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign stop_tick_c  = (state_q == RX_STOP) && bit_tick_c;
    assign parity_bad_c = (PARITY != PARITY_NONE) && (par_bit_q != parity_bit(PARITY, shift_q));

    // A low stop bit masks any parity result.
    assign frame_error_c  = stop_tick_c && !rx_sync_q;
    assign parity_error_c = stop_tick_c && rx_sync_q && parity_bad_c;
    assign byte_done_c    = stop_tick_c && rx_sync_q && !parity_bad_c;
    assign busy_c         = (state_q != RX_IDLE);
    assign byte_o         = shift_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= RX_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            clk_cnt_q <= clk_cnt_q + CW'(1);
            unique case (state_q)
                RX_IDLE: begin
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_sync_q) state_q <= RX_START;
                end
                RX_START: begin
                    // Mid-start-bit check rejects glitches shorter than half a bit.
                    if (half_tick_c) begin
                        clk_cnt_q <= '0;
                        state_q   <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (bit_tick_c) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BW'(DATA_BITS - 1))
                            state_q <= (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    if (bit_tick_c) begin
                        clk_cnt_q <= '0;
                        par_bit_q <= rx_sync_q;
                        state_q   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (bit_tick_c) begin
                        clk_cnt_q <= '0;
                        state_q   <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// Serial program loader: packs received UART bytes into big-endian words with
// auto-incrementing byte addresses, error strobes and partial-word timeout.
module uart_word_loader
    import uart_pkg::*;
#(
    parameter int unsigned           CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter parity_t               PARITY       = PARITY_NONE,
    parameter int unsigned           WORD_BYTES   = 4,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int unsigned           TIMEOUT_BITS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    input  logic                    load_enable,
    output logic [8*WORD_BYTES-1:0] instruction_word,
    output logic [ADDR_WIDTH-1:0]   byte_address,
    output logic                    word_valid,
    output logic                    frame_error,
    output logic                    parity_error,
    output logic                    busy
);

    localparam int unsigned WORD_W   = 8 * WORD_BYTES;
    localparam int unsigned CNT_W    = $clog2(WORD_BYTES + 1);
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
    localparam int unsigned TO_LAST  = (TO_LIMIT > 0) ? TO_LIMIT - 1 : 0;

    logic [DATA_BITS-1:0] rx_byte;
    logic                 byte_done_c;
    logic                 frame_error_c;
    logic                 parity_error_c;
    logic                 rx_busy_c;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY       (PARITY)
    ) u_rx (
        .clk            (clk),
        .reset          (reset),
        .rx_i           (rx),
        .byte_o         (rx_byte),
        .byte_done_c    (byte_done_c),
        .frame_error_c  (frame_error_c),
        .parity_error_c (parity_error_c),
        .busy_c         (rx_busy_c)
    );

    logic [WORD_W-1:0]     word_q,       word_d;
    logic [WORD_W-1:0]     instr_q,      instr_d;
    logic [CNT_W-1:0]      byte_cnt_q,   byte_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [TO_W-1:0]       to_cnt_q,     to_cnt_d;
    logic                  word_valid_q, word_valid_d;
    logic                  frame_err_q,  parity_err_q;
    logic                  busy_q,       busy_d;
    logic                  load_en_q;

    logic [WORD_W-1:0] word_shift_c;
    logic              timeout_c;

    assign word_shift_c = (word_q << 8) | WORD_W'(rx_byte);
    assign timeout_c    = (TIMEOUT_BITS != 0) && (byte_cnt_q != '0) && !rx_busy_c
                          && (to_cnt_q == TO_W'(TO_LAST));

    always_comb begin
        word_d       = word_q;
        instr_d      = instr_q;
        byte_cnt_d   = byte_cnt_q;
        addr_d       = addr_q;
        word_valid_d = 1'b0;
        to_cnt_d     = (byte_cnt_q == '0 || rx_busy_c || timeout_c) ? '0 : to_cnt_q + TO_W'(1);

        if (word_valid_q) addr_d = addr_q + ADDR_WIDTH'(WORD_BYTES);

        // A new load session restarts at the base address with an empty word.
        if (load_enable && !load_en_q) begin
            addr_d     = BASE_ADDR;
            byte_cnt_d = '0;
        end else if (!load_enable || frame_error_c || parity_error_c || timeout_c) begin
            byte_cnt_d = '0;
        end else if (byte_done_c) begin
            word_d = word_shift_c;
            if (byte_cnt_q == CNT_W'(WORD_BYTES - 1)) begin
                byte_cnt_d   = '0;
                word_valid_d = 1'b1;
                instr_d      = word_shift_c;
            end else begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end

        busy_d = rx_busy_c || (byte_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q       <= '0;
            instr_q      <= '0;
            byte_cnt_q   <= '0;
            addr_q       <= BASE_ADDR;
            to_cnt_q     <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
            load_en_q    <= 1'b0;
        end else begin
            word_q       <= word_d;
            instr_q      <= instr_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_q       <= addr_d;
            to_cnt_q     <= to_cnt_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_error_c;
            parity_err_q <= parity_error_c;
            busy_q       <= busy_d;
            load_en_q    <= load_enable;
        end
    end

    assign instruction_word = instr_q;
    assign byte_address     = addr_q;
    assign word_valid       = word_valid_q;
    assign frame_error      = frame_err_q;
    assign parity_error     = parity_err_q;
    assign busy             = busy_q;

endmodule
